// File: rtl/run_sequencer.sv
//------------------------------------------------------------------------------
// Module      : run_sequencer
// Description : Runs NPROG processor programs back-to-back. For each program
//               the core is held in init (core_start) for START_CYCLES cycles
//               with the program's start address presented, then the run time
//               is counted until core_done. A run that exceeds TIMEOUT cycles
//               parks the sequencer in an error state with the core held in
//               init until the next go.
// Ports       : CLK           - clock, rising edge
//               reset_n       - synchronous active-low reset
//               go            - start (or restart) the program sequence
//               core_done     - done flag from the processor (RUN only)
//               core_start    - processor init, high in START and ERR
//               start_address - PC load value of the current program
//               prog_idx      - index of the current program
//               busy          - high in START/RUN/NEXT
//               all_done      - high once every program has completed
//               timeout_err   - high after a run exceeded TIMEOUT
//               cycle_valid   - one-cycle pulse per completed program
//               cycle_ct      - run cycle count of the last completed program
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module run_sequencer #(
  parameter int            NPROG        = 3,
  parameter int            AW           = 10,
  parameter logic [AW-1:0] ADDR0        = AW'(0),
  parameter logic [AW-1:0] ADDR1        = AW'(128),
  parameter logic [AW-1:0] ADDR2        = AW'(256),
  parameter logic [AW-1:0] ADDR3        = AW'(384),
  parameter int            START_CYCLES = 2,
  parameter logic [15:0]   TIMEOUT      = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          go,
  input  logic          core_done,
  output logic          core_start,
  output logic [AW-1:0] start_address,
  output logic [1:0]    prog_idx,
  output logic          busy,
  output logic          all_done,
  output logic          timeout_err,
  output logic          cycle_valid,
  output logic [15:0]   cycle_ct
);

  localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);
  localparam logic [1:0]  LAST_IDX   = 2'(NPROG - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      prog_idx_q, prog_idx_d;
  logic [15:0]     start_cnt_q, start_cnt_d;
  logic [15:0]     run_cnt_q, run_cnt_d;
  logic            cycle_valid_q, cycle_valid_d;
  logic [15:0]     cycle_ct_q, cycle_ct_d;
  logic            core_start_q;
  logic            busy_q;
  logic            all_done_q;
  logic            timeout_err_q;
  logic [AW-1:0]   start_addr_q;

  function automatic logic [AW-1:0] addr_of(input logic [1:0] idx);
    case (idx)
      2'd0:    addr_of = ADDR0;
      2'd1:    addr_of = ADDR1;
      2'd2:    addr_of = ADDR2;
      default: addr_of = ADDR3;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    prog_idx_d    = prog_idx_q;
    start_cnt_d   = start_cnt_q;
    run_cnt_d     = run_cnt_q;
    cycle_valid_d = 1'b0;
    cycle_ct_d    = cycle_ct_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (go) begin
          state_d     = ST_START;
          prog_idx_d  = 2'd0;
          start_cnt_d = 16'd0;
        end
      end
      ST_START: begin
        if (start_cnt_q == START_LAST) begin
          state_d   = ST_RUN;
          run_cnt_d = 16'd0;
        end else begin
          start_cnt_d = start_cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        // done wins over the timeout check when both land in one cycle
        if (core_done) begin
          cycle_valid_d = 1'b1;
          cycle_ct_d    = run_cnt_q;
          state_d       = (prog_idx_q == LAST_IDX) ? ST_DONE : ST_NEXT;
        end else if (run_cnt_q == TIMEOUT) begin
          state_d = ST_ERR;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end
      ST_NEXT: begin
        state_d     = ST_START;
        prog_idx_d  = prog_idx_q + 2'd1;
        start_cnt_d = 16'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so that they are
  // registered yet always agree with the current state.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      prog_idx_q    <= 2'd0;
      start_cnt_q   <= 16'd0;
      run_cnt_q     <= 16'd0;
      cycle_valid_q <= 1'b0;
      cycle_ct_q    <= 16'd0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      start_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      prog_idx_q    <= prog_idx_d;
      start_cnt_q   <= start_cnt_d;
      run_cnt_q     <= run_cnt_d;
      cycle_valid_q <= cycle_valid_d;
      cycle_ct_q    <= cycle_ct_d;
      core_start_q  <= (state_d == ST_START) || (state_d == ST_ERR);
      busy_q        <= (state_d == ST_START) || (state_d == ST_RUN) ||
                       (state_d == ST_NEXT);
      all_done_q    <= (state_d == ST_DONE);
      timeout_err_q <= (state_d == ST_ERR);
      start_addr_q  <= (state_d == ST_IDLE) ? '0 : addr_of(prog_idx_d);
    end
  end

  assign core_start    = core_start_q;
  assign start_address = start_addr_q;
  assign prog_idx      = prog_idx_q;
  assign busy          = busy_q;
  assign all_done      = all_done_q;
  assign timeout_err   = timeout_err_q;
  assign cycle_valid   = cycle_valid_q;
  assign cycle_ct      = cycle_ct_q;

endmodule

`default_nettype wire

// File: tb/tb_run_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_run_sequencer
// Description : Self-checking bench for run_sequencer. A processor model
//               drives core_done a chosen number of RUN cycles after init is
//               released; the expected completion count is queued and a
//               separate monitor compares every cycle_valid pulse against it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_run_sequencer;

  localparam int TO = 20;
  localparam int NP = 3;
  localparam int SC = 2;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic        core_done = 1'b0;
  logic        core_start;
  logic [9:0]  start_address;
  logic [1:0]  prog_idx;
  logic        busy;
  logic        all_done;
  logic        timeout_err;
  logic        cycle_valid;
  logic [15:0] cycle_ct;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int last_ct = 0;
  int addr_tbl [4] = '{0, 128, 256, 384};

  always #5 CLK = ~CLK;

  run_sequencer #(
    .TIMEOUT(16'd20)
  ) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .go           (go),
    .core_done    (core_done),
    .core_start   (core_start),
    .start_address(start_address),
    .prog_idx     (prog_idx),
    .busy         (busy),
    .all_done     (all_done),
    .timeout_err  (timeout_err),
    .cycle_valid  (cycle_valid),
    .cycle_ct     (cycle_ct)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (cycle_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cycle_valid actual=1 required=0");
      end else begin
        last_ct = exp_q.pop_front();
        chk("cycle_ct", cycle_ct, last_ct);
      end
    end
  end

  // Init phase of program i: must last exactly SC cycles at the right address.
  task automatic start_phase(input int i, input bit noise);
    int n;
    int cnt;
    n = 0;
    cnt = 0;
    while (core_start !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("start_seen", core_start, 1);
    chk("start_prog_idx", prog_idx, i);
    chk("start_address", start_address, addr_tbl[i]);
    while (core_start === 1'b1 && cnt < 10) begin
      go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cnt++;
      @(negedge CLK);
    end
    go = 1'b0;
    chk("start_cycles", cnt, SC);
    chk("run_busy", busy, 1);
  endtask

  // Run phase: processor reports done after d idle RUN cycles; d beyond the
  // timeout limit means the processor never finishes.
  task automatic run_phase(input int d, input bit noise, output bit aborted);
    aborted = 1'b0;
    if (d > TO) begin
      core_done = 1'b0;
      for (int k = 1; k <= TO + 1; k++) begin
        go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge CLK);
        if (k == TO) chk("no_err_at_limit", timeout_err, 0);
      end
      go = 1'b0;
      chk("timeout_err", timeout_err, 1);
      chk("err_core_start", core_start, 1);
      chk("err_busy", busy, 0);
      aborted = 1'b1;
    end else begin
      for (int k = 0; k < d; k++) begin
        core_done = 1'b0;
        go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge CLK);
      end
      go = 1'b0;
      core_done = 1'b1;
      exp_q.push_back(d);
      @(negedge CLK);
      core_done = 1'b0;
      chk("no_timeout", timeout_err, 0);
    end
  endtask

  task automatic run_seq(input int d0, input int d1, input int d2,
                         input bit hold, input bit noise);
    int d[3];
    bit ab;
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    core_done = hold;
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_prog_idx", prog_idx, 0);
    chk("go_clears_err", timeout_err, 0);
    chk("go_clears_done", all_done, 0);
    for (int i = 0; i < NP; i++) begin
      start_phase(i, noise);
      run_phase(d[i], noise, ab);
      if (ab) return;
    end
    chk("all_done", all_done, 1);
    chk("done_busy", busy, 0);
    chk("done_core_start", core_start, 0);
  endtask

  task automatic reset_test();
    bit ab;
    core_done = 1'b0;
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    start_phase(0, 1'b0);
    run_phase(3, 1'b0, ab);
    start_phase(1, 1'b0);
    repeat (2) @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_cycle_valid", cycle_valid, 0);
    chk("rst_cycle_ct", cycle_ct, 0);
    chk("rst_start_address", start_address, 0);
    chk("rst_prog_idx", prog_idx, 0);
    reset_n = 1'b1;
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    chk("post_rst_go_busy", busy, 1);
    for (int i = 0; i < NP; i++) begin
      start_phase(i, 1'b0);
      run_phase(int'($urandom_range(0, 6)), 1'b0, ab);
    end
    chk("post_rst_all_done", all_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int dr[3];
    reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_core_start", core_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_start_address", start_address, 0);
    chk("reset_cycle_ct", cycle_ct, 0);
    chk("reset_all_done", all_done, 0);
    reset_n = 1'b1;
    core_done = 1'b1;
    @(negedge CLK);
    core_done = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_core_start", core_start, 0);

    run_seq(5, 5, 5, 1'b0, 1'b0);
    run_seq(0, 4, 2, 1'b1, 1'b0);
    run_seq(TO + 1, 0, 0, 1'b0, 1'b0);
    run_seq(TO, 1, TO, 1'b0, 1'b1);
    reset_test();

    for (int it = 0; it < 15; it++) begin
      for (int j = 0; j < 3; j++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      dr[j] = TO + 1;
        else if (r == 1) dr[j] = TO;
        else             dr[j] = int'($urandom_range(0, 12));
      end
      run_seq(dr[0], dr[1], dr[2], ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      r = int'($urandom_range(0, 3));
      repeat (r) begin
        core_done = 1'($urandom_range(0, 1));
        @(negedge CLK);
      end
      core_done = 1'b0;
    end

    repeat (3) @(negedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    chk("cycle_ct_held", cycle_ct, last_ct);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter NPROG, default 3: number of programs run back-to-back (range 1..4).
REQ-002 SHALL have parameter AW, default 10: start-address width, matching the PC width.
REQ-003 SHALL have parameters ADDR0/ADDR1/ADDR2/ADDR3, defaults 0/128/256/384: start address per program index.
REQ-004 SHALL have parameter START_CYCLES, default 2: number of cycles core_start is held high per program (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 16'hFFFF: maximum RUN cycle count before an error is flagged.
REQ-006 SHALL have port CLK, input, 1: clock; all state updates on the rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port go, input, 1: request to begin the program sequence.
REQ-009 SHALL have port core_done, input, 1: done flag from the processor.
REQ-010 SHALL have port core_start, output, 1: init/reset to the processor, active high.
REQ-011 SHALL have port start_address, output, AW: PC load value for the current program.
REQ-012 SHALL have port prog_idx, output, 2: index of the current program.
REQ-013 SHALL have port busy, output, 1: high in START/RUN/NEXT.
REQ-014 SHALL have port all_done, output, 1: high in DONE.
REQ-015 SHALL have port timeout_err, output, 1: high in ERR.
REQ-016 SHALL have port cycle_valid, output, 1: one-cycle pulse when a program completes.
REQ-017 SHALL have port cycle_ct, output, 16: RUN cycle count of the completed program; valid with cycle_valid and held until the next pulse.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, START, RUN, NEXT, DONE, ERR.
REQ-019 IDLE: core_start=0, busy=0; go=1 SHALL move to START with prog_idx=0 and the start counter cleared.
REQ-020 START: core_start=1 and start_address=ADDR[prog_idx]; after exactly START_CYCLES cycles, SHALL move to RUN with the run counter set to 0.
REQ-021 start_address SHALL remain ADDR[prog_idx] in all states except IDLE, where it is 0.
REQ-022 RUN: core_start=0; core_done SHALL be sampled every RUN cycle; core_done SHALL be ignored in all other states.
REQ-023 RUN with core_done=0: the run counter SHALL increment by 1; the count excludes the cycle in which done is seen, so done in the first RUN cycle yields a count of 0.
REQ-024 RUN with core_done=1: SHALL pulse cycle_valid, load cycle_ct with the run counter, then move to DONE if prog_idx==NPROG-1, else to NEXT.
REQ-025 RUN with core_done=0 and run counter==TIMEOUT: SHALL move to ERR; no cycle_valid pulse is produced.
REQ-026 When core_done=1 and the run counter==TIMEOUT occur in the same cycle, done SHALL take priority.
REQ-027 NEXT: one cycle; SHALL increment prog_idx, then move to START.
REQ-028 DONE: all_done=1, core_start=0; go=1 SHALL restart at START with prog_idx=0; otherwise the FSM stays in DONE.
REQ-029 ERR: timeout_err=1 and core_start=1 (processor held in init); go=1 SHALL restart at START with prog_idx=0, clearing timeout_err.
REQ-030 go SHALL be ignored in START, RUN and NEXT.
REQ-031 Counters SHALL be 16-bit and SHALL never wrap, because TIMEOUT bounds the run counter.

Reset
REQ-032 reset_n=0 at a rising edge SHALL force, from any state, including mid-RUN: IDLE, prog_idx=0, core_start=0, busy=0, all_done=0, timeout_err=0, cycle_valid=0, cycle_ct=0, start_address=0, all counters 0.
REQ-033 The first go SHALL be accepted on the first cycle after reset_n returns high.

Verification
REQ-034 Defaults, go pulse, core_done raised after the 5th RUN cycle for each program -> core_start high 2 cycles per program; start_address 0, 128, 256 in turn; three cycle_valid pulses each with cycle_ct=5; all_done=1.
REQ-035 core_done held high throughout START -> ignored during START; cycle_ct=0 on the first RUN cycle.
REQ-036 TIMEOUT=20, core_done never asserted -> ERR after 21 RUN cycles; timeout_err=1, core_start=1, no cycle_valid; go -> START, prog_idx=0, timeout_err=0.
REQ-037 TIMEOUT=20, core_done rises exactly when the count reaches 20 -> cycle_valid with cycle_ct=20; no ERR.
REQ-038 reset_n low mid-RUN on program 1 -> next cycle IDLE with all outputs 0; go then starts from prog_idx=0 at address 0.
REQ-039 go pulses during RUN, then go in DONE -> RUN-time pulses have no effect; go in DONE restarts the sequence at ADDR0.
